// File: rtl/dice_value_gen.sv
// dice_value_gen
//   Consumes the ring-oscillator TRNG bit stream and turns it into a uniform
//   die face. A roll request starts the oscillator. The raw bit is
//   synchronized and optionally von Neumann debiased. Accepted bits are
//   shifted into 3-bit candidates, and candidates 0 and 7 are rejected so
//   that faces 1..6 are equally likely. The oscillator is halted again when a
//   face is produced. If no bit is accepted for TIMEOUT_CYCLES cycles, the
//   block parks in a sticky fault state.
//
// Parameters
//   DEBIAS          1 = von Neumann pair debiasing, 0 = accept every bit
//   TIMEOUT_CYCLES  cycles without an accepted bit before fault (>= 4)
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   roll         roll request, ignored while busy
//   random_in    raw TRNG bit, asynchronous to clk
//   stop         oscillator halt (1 = halted)
//   busy         collection in progress
//   value_valid  one-cycle pulse when value is updated
//   value        last die face 1..6 (0 only after reset)
//   fault        sticky entropy-source stall flag
module dice_value_gen #(
  parameter int DEBIAS         = 1,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       roll,
  input  logic       random_in,
  output logic       stop,
  output logic       busy,
  output logic       value_valid,
  output logic [2:0] value,
  output logic       fault
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, FLUSH, COLLECT, FAULT} state_t;

  state_t        state, state_nx;
  logic          rnd_p0, rnd_p1;
  logic          flush_ph, flush_nx;
  logic [1:0]    bit_cnt, cnt_nx;
  logic          pair_flag, pair_nx;
  logic          pair_first, first_nx;
  logic [1:0]    sh, sh_nx;
  logic [TW-1:0] timer, timer_nx, timer_inc;
  logic [2:0]    value_nx;
  logic          vv_nx;
  logic          accept, b;
  logic [2:0]    cand;

  // Only 1..6 are valid faces; 0 and 7 are rejected to keep the distribution uniform.
  function automatic logic face_ok(input logic [2:0] c);
    return (c != 3'd0) && (c != 3'd7);
  endfunction

  // Synchronizer stage: rnd_p1 is the synchronized sample s.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rnd_p0 <= 1'b0;
      rnd_p1 <= 1'b0;
    end else begin
      rnd_p0 <= random_in;
      rnd_p1 <= rnd_p0;
    end
  end

  // State and collection registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      flush_ph    <= 1'b0;
      bit_cnt     <= 2'd0;
      pair_flag   <= 1'b0;
      pair_first  <= 1'b0;
      sh          <= 2'd0;
      timer       <= '0;
      value       <= 3'd0;
      value_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      flush_ph    <= flush_nx;
      bit_cnt     <= cnt_nx;
      pair_flag   <= pair_nx;
      pair_first  <= first_nx;
      sh          <= sh_nx;
      timer       <= timer_nx;
      value       <= value_nx;
      value_valid <= vv_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    flush_nx  = flush_ph;
    cnt_nx    = bit_cnt;
    pair_nx   = pair_flag;
    first_nx  = pair_first;
    sh_nx     = sh;
    timer_nx  = timer;
    value_nx  = value;
    vv_nx     = 1'b0;
    accept    = 1'b0;
    b         = 1'b0;
    cand      = {sh, 1'b0};
    timer_inc = timer + TW'(1);

    case (state)
      IDLE, FAULT: begin
        if (roll) begin
          state_nx = FLUSH;
          flush_nx = 1'b0;
          cnt_nx   = 2'd0;
          pair_nx  = 1'b0;
          first_nx = 1'b0;
          sh_nx    = 2'd0;
          timer_nx = '0;
        end
      end

      FLUSH: begin
        // Two cycles of discarded samples let the oscillator settle and
        // flush stale synchronizer contents.
        flush_nx = 1'b1;
        timer_nx = timer_inc;
        if (timer_inc == TMAX) state_nx = FAULT;
        else if (flush_ph)     state_nx = COLLECT;
      end

      COLLECT: begin
        if (DEBIAS == 0) begin
          accept = 1'b1;
          b      = rnd_p1;
        end else if (!pair_flag) begin
          pair_nx  = 1'b1;
          first_nx = rnd_p1;
        end else begin
          // 10 -> 1, 01 -> 0; equal pairs carry bias and are dropped.
          pair_nx = 1'b0;
          if (pair_first != rnd_p1) begin
            accept = 1'b1;
            b      = pair_first;
          end
        end

        cand = {sh, b};

        if (accept) begin
          // An accept always clears the timer, even on the timeout cycle.
          sh_nx    = cand[1:0];
          timer_nx = '0;
          if (bit_cnt == 2'd2) begin
            cnt_nx = 2'd0;
            if (face_ok(cand)) begin
              value_nx = cand;
              vv_nx    = 1'b1;
              state_nx = IDLE;
            end
          end else begin
            cnt_nx = bit_cnt + 2'd1;
          end
        end else begin
          timer_nx = timer_inc;
          if (timer_inc == TMAX) state_nx = FAULT;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign stop  = (state == IDLE) || (state == FAULT);
  assign busy  = (state == FLUSH) || (state == COLLECT);
  assign fault = (state == FAULT);

endmodule

// File: tb/tb_dice_value_gen.sv
// tb_dice_value_gen
//   Two instances: dut_a without debiasing (default timeout) and dut_b with
//   debiasing and a short timeout of 16 cycles. Inputs change just after the
//   falling edge, and outputs are sampled on the falling edge. Expected faces
//   are queued when a roll is issued and are matched by a monitor whenever
//   value_valid is seen.
module tb_dice_value_gen;

  logic       clk;
  logic       reset_n;
  logic       roll_a, rnd_a, roll_b, rnd_b;
  logic       stop_a, busy_a, vv_a, fault_a;
  logic       stop_b, busy_b, vv_b, fault_b;
  logic [2:0] value_a, value_b;

  int n_cmp = 0;
  int n_err = 0;
  int q_a[$];
  int q_b[$];
  int pushed_a = 0, pushed_b = 0;
  int pulses_a = 0, pulses_b = 0;

  dice_value_gen #(.DEBIAS(0), .TIMEOUT_CYCLES(1023)) dut_a (
    .clk(clk), .reset_n(reset_n), .roll(roll_a), .random_in(rnd_a),
    .stop(stop_a), .busy(busy_a), .value_valid(vv_a), .value(value_a),
    .fault(fault_a)
  );

  dice_value_gen #(.DEBIAS(1), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .roll(roll_b), .random_in(rnd_b),
    .stop(stop_b), .busy(busy_b), .value_valid(vv_b), .value(value_b),
    .fault(fault_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic g_busy(input bit w);  return w ? busy_b  : busy_a;  endfunction
  function automatic logic g_stop(input bit w);  return w ? stop_b  : stop_a;  endfunction
  function automatic logic g_vv(input bit w);    return w ? vv_b    : vv_a;    endfunction
  function automatic logic g_fault(input bit w); return w ? fault_b : fault_a; endfunction
  function automatic logic [2:0] g_value(input bit w); return w ? value_b : value_a; endfunction

  task automatic set_in(input bit w, input logic r, input logic d);
    if (w) begin roll_b = r; rnd_b = d; end
    else   begin roll_a = r; rnd_a = d; end
  endtask

  // Roll at e0, then random_in at e1..en carries the n bits MSB first, so
  // the synchronized stream at e3..e(n+2) is exactly those bits. roll_mask
  // bit k raises roll again at edge ek.
  task automatic run_roll(input bit w, input logic [15:0] bits, input int n,
                          input logic [15:0] roll_mask, input int exp_val);
    int total;
    total = n + 2;
    if (w) begin q_b.push_back(exp_val); pushed_b++; end
    else   begin q_a.push_back(exp_val); pushed_a++; end
    set_in(w, 1'b1, 1'b0);
    step();
    chk("e0_busy",  32'(g_busy(w)),  1);
    chk("e0_stop",  32'(g_stop(w)),  0);
    chk("e0_fault", 32'(g_fault(w)), 0);
    chk("e0_valid", 32'(g_vv(w)),    0);
    for (int k = 1; k <= total; k++) begin
      set_in(w, roll_mask[k], (k <= n) ? bits[n-k] : 1'b0);
      step();
      if (k < total) begin
        chk("mid_busy",  32'(g_busy(w)), 1);
        chk("mid_valid", 32'(g_vv(w)),   0);
      end
    end
    chk("done_valid", 32'(g_vv(w)),    1);
    chk("done_value", 32'(g_value(w)), exp_val);
    chk("done_busy",  32'(g_busy(w)),  0);
    chk("done_stop",  32'(g_stop(w)),  1);
    set_in(w, 1'b0, 1'b0);
    step();
    chk("post_valid", 32'(g_vv(w)),   0);
    chk("post_busy",  32'(g_busy(w)), 0);
  endtask

  // Scoreboard monitor: every value_valid must match the oldest queued face.
  always @(negedge clk) begin
    if (reset_n) begin
      if (vv_a) begin
        pulses_a++;
        if (q_a.size() == 0) chk("a_unexpected_valid", 1, 0);
        else chk("a_sb_value", 32'(value_a), 32'(q_a.pop_front()));
      end
      if (vv_b) begin
        pulses_b++;
        if (q_b.size() == 0) chk("b_unexpected_valid", 1, 0);
        else chk("b_sb_value", 32'(value_b), 32'(q_b.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    roll_a = 1'b0; rnd_a = 1'b0; roll_b = 1'b0; rnd_b = 1'b0;
    @(negedge clk);
    rnd_a = 1'b1; rnd_b = 1'b1;
    @(negedge clk);
    chk("rst_stop_a",  32'(stop_a),  1);
    chk("rst_busy_a",  32'(busy_a),  0);
    chk("rst_valid_a", 32'(vv_a),    0);
    chk("rst_value_a", 32'(value_a), 0);
    chk("rst_fault_a", 32'(fault_a), 0);
    chk("rst_stop_b",  32'(stop_b),  1);
    chk("rst_value_b", 32'(value_b), 0);
    reset_n = 1'b1;
    rnd_a = 1'b0; rnd_b = 1'b0;
    step();
    chk("idle_busy_a", 32'(busy_a), 0);

    // No debias: 1,0,1 -> 5 after e5.
    run_roll(1'b0, 16'b101, 3, 16'h0, 5);
    // No debias: 1,1,1 rejected, then 0,1,0 -> 2 after e8.
    run_roll(1'b0, 16'b111010, 6, 16'h0, 2);
    // Rolls at e1, e3, e4 and at the result edge e5 are all ignored.
    run_roll(1'b0, 16'b011, 3, 16'b0000_0000_0011_1010, 3);
    // Debias: pairs 00,10,11,01,10 -> 1,0,1 -> 5 after e12.
    run_roll(1'b1, 16'b0010110110, 10, 16'h0, 5);
    // Debias: pairs 10,10,01 -> 1,1,0 -> 6 after e8.
    run_roll(1'b1, 16'b101001, 6, 16'h0, 6);

    // Stalled source on dut_b: fault after e16, value untouched.
    set_in(1'b1, 1'b1, 1'b0);
    step();
    set_in(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("stall_busy",  32'(busy_b),  1);
      chk("stall_fault", 32'(fault_b), 0);
    end
    step();
    chk("fault_flag",  32'(fault_b), 1);
    chk("fault_stop",  32'(stop_b),  1);
    chk("fault_busy",  32'(busy_b),  0);
    chk("fault_value", 32'(value_b), 6);
    chk("fault_valid", 32'(vv_b),    0);
    step();
    chk("fault_sticky", 32'(fault_b), 1);
    // A new roll clears fault and restarts: pairs 01,10,10 -> 0,1,1 -> 3.
    run_roll(1'b1, 16'b011010, 6, 16'h0, 3);

    // Asynchronous reset in the middle of COLLECT with random_in toggling.
    set_in(1'b0, 1'b1, 1'b0);
    step();
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b0, 1'b0, k[0]);
      step();
    end
    chk("pre_rst_busy", 32'(busy_a), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_stop",  32'(stop_a),  1);
    chk("arst_busy",  32'(busy_a),  0);
    chk("arst_valid", 32'(vv_a),    0);
    chk("arst_value", 32'(value_a), 0);
    chk("arst_fault", 32'(fault_a), 0);
    @(negedge clk);
    reset_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    step();
    chk("arst_idle_busy", 32'(busy_a), 0);
    // Recovery after reset: 1,1,0 -> 6.
    run_roll(1'b0, 16'b110, 3, 16'h0, 6);

    step();
    chk("q_a_empty",  q_a.size(), 0);
    chk("q_b_empty",  q_b.size(), 0);
    chk("pulses_a",   pulses_a, pushed_a);
    chk("pulses_b",   pulses_b, pushed_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
